// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand-1 issue sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned REG_W    = 5;

    localparam logic [OPCODE_W-1:0] OPCODE_RTYPE = 6'h00;

    localparam logic [FUNCT_W-1:0] FUNCT_SLL  = 6'h00;
    localparam logic [FUNCT_W-1:0] FUNCT_SRL  = 6'h02;
    localparam logic [FUNCT_W-1:0] FUNCT_SRA  = 6'h03;
    localparam logic [FUNCT_W-1:0] FUNCT_SLLV = 6'h04;
    localparam logic [FUNCT_W-1:0] FUNCT_SRLV = 6'h06;
    localparam logic [FUNCT_W-1:0] FUNCT_SRAV = 6'h07;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        EXEC
    } seq_state_e;

    typedef enum logic [1:0] {
        PLAIN,
        SHIFT_IMM,
        SHIFT_VAR
    } op_class_e;

endpackage

// File: rtl/alu_shift_classifier.sv
// Combinational opcode/funct decode into shift-operand classes.
module alu_shift_classifier
    import alu_seq_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    output op_class_e           op_class_o
);

    // Only R-type shift functs select the shift-amount operand path
    always_comb begin
        op_class_o = PLAIN;
        if (opcode_i == OPCODE_RTYPE) begin
            case (funct_i)
                FUNCT_SLL, FUNCT_SRL, FUNCT_SRA:    op_class_o = SHIFT_IMM;
                FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: op_class_o = SHIFT_VAR;
                default:                            op_class_o = PLAIN;
            endcase
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Issue controller for the ALU operand-1 path: classifies decoded ops,
// drives the data1 mux select / shift-amount operand and counts issued ops.
// Optional feature: define ALU_SEQ_FWD_EN for a one-entry result bypass
// feeding variable-shift amounts.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    input  logic [SHAMT_W-1:0]  shamt_i,
    input  logic [REG_W-1:0]    rs_addr_i,
    input  logic [REG_W-1:0]    rd_addr_i,
    input  logic [DATA_W-1:0]   rs_data_i,
    input  logic [DATA_W-1:0]   alu_result_i,
    output logic                alu_valid_o,
    input  logic                alu_ready_i,
    output logic                use_shift_o,
    output logic [DATA_W-1:0]   shift_data_o,
    output logic [FUNCT_W-1:0]  alu_funct_o,
    output logic [CNT_W-1:0]    op_count_o
);

    seq_state_e           state_q, state_d;
    op_class_e            op_class;
    logic                 use_shift_q, use_shift_d;
    logic [SHAMT_W-1:0]   shift_q, shift_d;
    logic [SHAMT_W-1:0]   rs_lat_q, rs_lat_d;
    logic [FUNCT_W-1:0]   funct_q, funct_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 issue;
    logic                 accept;
    logic [SHAMT_W-1:0]   rs_src;

`ifdef ALU_SEQ_FWD_EN
    logic [REG_W-1:0]     rd_q, rd_d;
    logic [REG_W-1:0]     byp_rd_q, byp_rd_d;
    logic [SHAMT_W-1:0]   byp_data_q, byp_data_d;
    logic                 unused_bits;
    assign unused_bits = ^{rs_data_i[DATA_W-1:SHAMT_W], alu_result_i[DATA_W-1:SHAMT_W]};
`else
    logic                 unused_bits;
    assign unused_bits = ^{rs_data_i[DATA_W-1:SHAMT_W], rd_addr_i, alu_result_i};
`endif

    alu_shift_classifier u_classifier (
        .opcode_i   (opcode_i),
        .funct_i    (funct_i),
        .op_class_o (op_class)
    );

    // Next-state, operand next values and handshake outputs
    always_comb begin
        state_d     = state_q;
        use_shift_d = use_shift_q;
        shift_d     = shift_q;
        rs_lat_d    = rs_lat_q;
        funct_d     = funct_q;
        cnt_d       = cnt_q;
        rs_src      = rs_data_i[SHAMT_W-1:0];
`ifdef ALU_SEQ_FWD_EN
        rd_d        = rd_q;
        byp_rd_d    = byp_rd_q;
        byp_data_d  = byp_data_q;
`endif

        alu_valid_o   = (state_q == EXEC);
        issue         = alu_valid_o && alu_ready_i;
        instr_ready_o = (state_q == IDLE) || issue;
        accept        = instr_valid_i && instr_ready_o;

`ifdef ALU_SEQ_FWD_EN
        // Newest producer wins: the op completing now, then the retained entry
        if (issue && (rd_q != '0) && (rd_q == rs_addr_i)) begin
            rs_src = alu_result_i[SHAMT_W-1:0];
        end else if ((byp_rd_q != '0) && (byp_rd_q == rs_addr_i)) begin
            rs_src = byp_data_q;
        end
        if (issue) begin
            byp_rd_d   = rd_q;
            byp_data_d = alu_result_i[SHAMT_W-1:0];
        end
`endif

        if (issue) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            PREP: begin
                state_d     = EXEC;
                use_shift_d = 1'b1;
                shift_d     = rs_lat_q;
            end
            IDLE, EXEC: begin
                if (accept) begin
                    funct_d = funct_i;
`ifdef ALU_SEQ_FWD_EN
                    rd_d    = rd_addr_i;
`endif
                    case (op_class)
                        SHIFT_IMM: begin
                            state_d     = EXEC;
                            use_shift_d = 1'b1;
                            shift_d     = shamt_i;
                        end
                        SHIFT_VAR: begin
                            state_d  = PREP;
                            rs_lat_d = rs_src;
                        end
                        default: begin
                            state_d     = EXEC;
                            use_shift_d = 1'b0;
                            shift_d     = '0;
                        end
                    endcase
                end else if (issue) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and operand registers; reset drops any in-flight op
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            use_shift_q <= 1'b0;
            shift_q     <= '0;
            rs_lat_q    <= '0;
            funct_q     <= '0;
            cnt_q       <= '0;
`ifdef ALU_SEQ_FWD_EN
            rd_q        <= '0;
            byp_rd_q    <= '0;
            byp_data_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            use_shift_q <= use_shift_d;
            shift_q     <= shift_d;
            rs_lat_q    <= rs_lat_d;
            funct_q     <= funct_d;
            cnt_q       <= cnt_d;
`ifdef ALU_SEQ_FWD_EN
            rd_q        <= rd_d;
            byp_rd_q    <= byp_rd_d;
            byp_data_q  <= byp_data_d;
`endif
        end
    end

    assign use_shift_o  = use_shift_q;
    assign shift_data_o = DATA_W'(shift_q);
    assign alu_funct_o  = funct_q;
    assign op_count_o   = cnt_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: directed scenarios plus random traffic,
// checked against a transaction-level model of the issue behaviour.
module tb_alu_operand_sequencer;

    localparam int unsigned CNT_W = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [5:0]  opcode_i = '0;
    logic [5:0]  funct_i = '0;
    logic [4:0]  shamt_i = '0;
    logic [4:0]  rs_addr_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic [31:0] rs_data_i = '0;
    logic [31:0] alu_result_i = '0;
    logic        alu_valid_o;
    logic        alu_ready_i = 1'b0;
    logic        use_shift_o;
    logic [31:0] shift_data_o;
    logic [5:0]  alu_funct_o;
    logic [CNT_W-1:0] op_count_o;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic             m_present, m_prep, m_use;
    logic [31:0]      m_shift;
    logic [5:0]       m_funct;
    logic [4:0]       m_lat, m_rd, byp_rd, byp_data;
    logic [CNT_W-1:0] m_cnt;

    always #5 clk_i = ~clk_i;

    alu_operand_sequencer #(.CNT_W(CNT_W), .SHAMT_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .opcode_i(opcode_i), .funct_i(funct_i), .shamt_i(shamt_i),
        .rs_addr_i(rs_addr_i), .rd_addr_i(rd_addr_i),
        .rs_data_i(rs_data_i), .alu_result_i(alu_result_i),
        .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
        .use_shift_o(use_shift_o), .shift_data_o(shift_data_o),
        .alu_funct_o(alu_funct_o), .op_count_o(op_count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 plain, 1 immediate shift, 2 register shift
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op != 6'd0) return 0;
        if (fn == 6'd0 || fn == 6'd2 || fn == 6'd3) return 1;
        if (fn == 6'd4 || fn == 6'd6 || fn == 6'd7) return 2;
        return 0;
    endfunction

    function automatic void model_reset();
        m_present = 1'b0; m_prep = 1'b0; m_use = 1'b0; m_shift = '0;
        m_funct = '0; m_lat = '0; m_rd = '0; byp_rd = '0; byp_data = '0;
        m_cnt = '0;
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        chk("rst_valid", 32'(alu_valid_o), 32'd0);
        chk("rst_count", 32'(op_count_o), 32'd0);
        chk("rst_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_use", 32'(use_shift_o), 32'd0);
        chk("rst_shift", shift_data_o, 32'd0);
        chk("rst_funct", 32'(alu_funct_o), 32'd0);
        model_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    // one clock: check ready, advance the model, compare registered outputs
    task automatic tick();
        logic exp_ready, done, acc;
        logic [4:0] src;
        #1;
        exp_ready = !m_prep && (!m_present || alu_ready_i);
        chk("instr_ready", 32'(instr_ready_o), 32'(exp_ready));
        done = m_present && alu_ready_i;
        acc  = instr_valid_i && exp_ready;
        src  = rs_data_i[4:0];
`ifdef ALU_SEQ_FWD_EN
        if (done && m_rd != 5'd0 && m_rd == rs_addr_i) src = alu_result_i[4:0];
        else if (byp_rd != 5'd0 && byp_rd == rs_addr_i) src = byp_data;
`endif
        if (done) begin
            m_cnt    = m_cnt + 1'b1;
            byp_rd   = m_rd;
            byp_data = alu_result_i[4:0];
        end
        if (m_prep) begin
            m_prep = 1'b0; m_present = 1'b1; m_use = 1'b1; m_shift = {27'd0, m_lat};
        end else if (acc) begin
            m_funct = funct_i;
            m_rd    = rd_addr_i;
            case (classify(opcode_i, funct_i))
                1: begin m_present = 1'b1; m_use = 1'b1; m_shift = {27'd0, shamt_i}; end
                2: begin m_present = 1'b0; m_prep = 1'b1; m_lat = src; end
                default: begin m_present = 1'b1; m_use = 1'b0; m_shift = '0; end
            endcase
        end else if (done) begin
            m_present = 1'b0;
        end
        @(posedge clk_i); #1;
        chk("alu_valid", 32'(alu_valid_o), 32'(m_present));
        chk("op_count", 32'(op_count_o), 32'(m_cnt));
        if (m_present) begin
            chk("use_shift", 32'(use_shift_o), 32'(m_use));
            chk("shift_data", shift_data_o, m_shift);
            chk("alu_funct", 32'(alu_funct_o), 32'(m_funct));
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [4:0] rs, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic rdy, input logic [31:0] res);
        instr_valid_i = v; opcode_i = op; funct_i = fn; shamt_i = sh;
        rs_addr_i = rs; rd_addr_i = rd; rs_data_i = rsd;
        alu_ready_i = rdy; alu_result_i = res;
    endtask

    initial begin
        logic [5:0] fn_tab [9];
        fn_tab = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h2a};
        model_reset();
        do_reset();

        // SLL shamt=7 with ALU ready: presented next cycle, counted the one after
        drive(1, 6'h00, 6'h00, 5'd7, 5'd0, 5'd0, 32'h0, 1, 32'h0);
        tick();
        chk("sll_use", 32'(use_shift_o), 32'd1);
        chk("sll_shift", shift_data_o, 32'h7);
        drive(0, 6'h00, 6'h20, 5'd0, 5'd0, 5'd0, 32'h0, 1, 32'h0);
        tick();
        chk("sll_count", 32'(op_count_o), 32'd1);

        // SRAV: extra PREP cycle, only rs[4:0] used, new op ignored while in PREP
        drive(1, 6'h00, 6'h07, 5'd0, 5'd3, 5'd0, 32'hFFFF_FF23, 0, 32'h0);
        tick();
        drive(1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd1, 32'h0, 0, 32'h0);
        #1;
        chk("prep_ready", 32'(instr_ready_o), 32'd0);
        chk("prep_valid", 32'(alu_valid_o), 32'd0);
        tick();
        chk("srav_shift", shift_data_o, 32'h3);

        // ADD accepted as SRAV issues, then held for 3 cycles of backpressure
        alu_ready_i = 1'b1;
        tick();
        alu_ready_i = 1'b0;
        opcode_i = 6'h08;
        for (int i = 0; i < 3; i++) tick();
        chk("hold_count", 32'(op_count_o), 32'd2);
        chk("hold_funct", 32'(alu_funct_o), 32'h20);
        // release with next op valid: accepted in the same cycle
        drive(1, 6'h00, 6'h00, 5'd9, 5'd0, 5'd0, 32'h0, 1, 32'h0);
        #1;
        chk("b2b_ready", 32'(instr_ready_o), 32'd1);
        tick();
        chk("b2b_shift", shift_data_o, 32'h9);
        chk("b2b_count", 32'(op_count_o), 32'd3);

        // ADD rd=5 produces 0x1F, then SLLV rs=5
        drive(1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd5, 32'h0, 1, 32'h0);
        tick();
        drive(0, 6'h00, 6'h20, 5'd0, 5'd0, 5'd0, 32'h0, 1, 32'h1F);
        tick();
        drive(1, 6'h00, 6'h04, 5'd0, 5'd5, 5'd0, 32'h2, 0, 32'h0);
        tick();
        instr_valid_i = 1'b0;
        tick();
`ifdef ALU_SEQ_FWD_EN
        chk("fwd_shift", shift_data_o, 32'h1F);
`else
        chk("nofwd_shift", shift_data_o, 32'h2);
`endif
        alu_ready_i = 1'b1;
        tick();

        // reset while an op waits in EXEC
        drive(1, 6'h08, 6'h00, 5'd0, 5'd0, 5'd2, 32'h0, 0, 32'h0);
        tick();
        instr_valid_i = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(alu_valid_o), 32'd1);
        do_reset();

        // random traffic
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00,
                  fn_tab[$urandom_range(0, 8)],
                  5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom, ($urandom_range(0, 9) < 7), $urandom);
            tick();
        end

        // counter wrap with back-to-back plain ops
        do_reset();
        drive(1, 6'h08, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 1, 32'h0);
        for (int i = 0; i < (1 << CNT_W) + 1; i++) tick();
        chk("wrap_count", 32'(op_count_o), 32'd0);
        chk("wrap_valid", 32'(alu_valid_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
